// File: rtl/period_meter.sv
// Period and high-time meter: times a slow, asynchronous input against C_50Mhz
// and reports both intervals in system-clock cycles after every rising edge.
module period_meter #(
  parameter int CNT_W       = 25,
  parameter int TIMEOUT     = 25000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             C_50Mhz,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             busy,
  output logic             timeout_err
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_CNT     = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_d;
  logic                   sig_s;
  logic                   rise;
  logic                   fall;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       high_cap;

  // Both edges see the same synchronizer latency, so intervals stay exact.
  always_ff @(posedge C_50Mhz) begin
    if (reset) begin
      sync_q <= '0;
      sig_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sig_d  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sig_s = sync_q[SYNC_STAGES-1];
  assign rise  = sig_s & ~sig_d;
  assign fall  = ~sig_s & sig_d;

  always_ff @(posedge C_50Mhz) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      high_cap    <= '0;
      period      <= '0;
      high_time   <= '0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      valid       <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= ARM;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ARM: begin
          if (rise) begin
            state <= MEASURE;
            cnt   <= ONE_CNT;
          end else if (cnt == TIMEOUT_CNT) begin
            state       <= IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + ONE_CNT;
          end
        end
        MEASURE: begin
          // A rise on the timeout cycle still completes a valid measurement.
          if (rise) begin
            period    <= cnt;
            high_time <= high_cap;
            valid     <= 1'b1;
            cnt       <= ONE_CNT;
            if (!continuous) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (cnt == TIMEOUT_CNT) begin
            state       <= IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + ONE_CNT;
            if (fall) begin
              high_cap <= cnt;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
